decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port flush, input, 1, branch/jump redirect; discards the word in flight.
REQ-004 SHALL have port stall, input, 1, downstream hold request; output register keeps its contents.
REQ-005 SHALL have port in_valid, input, 1, fetch presents an instruction.
REQ-006 SHALL have port in_instr, input, 16, raw instruction: [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [5:0] imm6, [8:0] imm9.
REQ-007 SHALL have port in_ready, output, 1, decode accepts in_instr this cycle.
REQ-008 SHALL have port out_valid, output, 1, out_word holds a real instruction.
REQ-009 SHALL have port out_word, output, 19, decoded word for register read.
REQ-010 SHALL have port halted, output, 1, HALT decoded; sticky.
REQ-011 SHALL have port illegal, output, 1, undefined opcode seen; sticky.

Function
REQ-012 SHALL define out_word as: [18:16] rd (store-data reg for SW), [15:13] rs1, [12:10] rs2 (R), [12:7] imm6 (I), [15:7] imm9 (J), [6:3] opcode, [2] reg-write enable, [1:0] type (11 R, 10 I, 01 J, 00 NOP).
REQ-013 SHALL decode opcodes 0001-0101 ADD/SUB/AND/OR/XOR as R with we=1, 0110 ADDI and 0111 LW as I with we=1, 1000 SW and 1001 BEQ as I with we=0, 1010 JMP as J with we=0, 1011 JAL as J with we=1 and rd forced to 7.
REQ-014 SHALL zero every field not defined for the decoded type.
REQ-015 SHALL treat opcode 0000 as a NOP: all-zero word, out_valid=0.
REQ-016 SHALL treat opcodes 1100-1110 as a NOP and set illegal.
REQ-017 SHALL have a registered output with one-cycle latency: an instruction accepted in cycle N appears on out_word/out_valid in cycle N+1.
REQ-018 SHALL accept an instruction only when in_valid && in_ready.
REQ-019 SHALL drive in_ready = (state==RUN) && !stall && !hazard.
REQ-020 SHALL hold out_word and out_valid unchanged while stall=1.
REQ-021 SHALL have states RUN, BUBBLE and HALT.
REQ-022 SHALL assert hazard in RUN when the current output word is LW with rd==X and the incoming instruction reads X (rs1 for R/I types, rs2 for R type, rd for SW).
REQ-023 SHALL, on a hazard without stall, load an all-zero word with out_valid=0 and go to BUBBLE.
REQ-024 SHALL leave BUBBLE for RUN after one cycle, provided stall=0.
REQ-025 SHALL, when 1111 HALT is accepted, load a NOP, set halted and go to HALT.
REQ-026 SHALL keep in_ready=0 and out_valid=0 in HALT until reset.
REQ-027 SHALL, on flush, load an all-zero word with out_valid=0 and return BUBBLE to RUN on the next edge.
REQ-028 SHALL give flush priority over stall, hazard and acceptance, and discard the instruction presented in that cycle.
REQ-029 SHALL, when in_valid=0 in RUN with no stall, load a NOP bubble.
REQ-030 SHALL NOT let flush exit HALT.

Reset
REQ-031 SHALL, while resetn=0, immediately force state=RUN, out_word=0, out_valid=0, halted=0, illegal=0.
REQ-032 SHALL force in_ready=0 while resetn=0.
REQ-033 SHALL discard any bubble or HALT in progress on reset mid-operation.

Structure
REQ-034 SHALL place opcode constants, type codes, field bit positions and state encodings in the shared package isa_pkg, which Register_Read also uses.
REQ-035 SHALL contain one combinational sub-module, instr_decoder (16-bit instruction in, 19-bit word plus is_load/is_halt/is_illegal out); the FSM, hazard compare and registers stay in decode_stage.

Verification
REQ-036 SHALL check: in_instr=16'h1650 (ADD r3,r1,r2) -> next cycle out_word=19'h3280F, out_valid=1.
REQ-037 SHALL check: in_instr=16'h6445 (ADDI r2,r1,#5) -> out_word=19'h222B6.
REQ-038 SHALL check: LW r2 followed by ADD r3,r2,r1 -> one bubble cycle with in_ready=0, then the ADD word.
REQ-039 SHALL check: stall held 3 cycles -> out_word stable, in_ready=0; flush asserted together with stall -> zero word next cycle.
REQ-040 SHALL check: HALT, then valid ADDs -> halted=1, out_valid=0 indefinitely; flush ignored; resetn pulse restores RUN.
REQ-041 SHALL check: opcode 1101 -> illegal=1 sticky, out_valid=0, next ADD decodes normally.

Source files
------------

// File: rtl/isa_pkg.sv
// isa_pkg: instruction-set constants shared by the decode and register-read stages.
// This file holds the opcodes, the type codes, the bit positions of both formats,
// and the decode FSM state encoding.
package isa_pkg;

    localparam int INSTR_W = 16;
    localparam int WORD_W  = 19;
    localparam int REG_W   = 3;

    // Opcodes (instruction bits [15:12])
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_LW   = 4'h7;
    localparam logic [3:0] OP_SW   = 4'h8;
    localparam logic [3:0] OP_BEQ  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_JAL  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Type codes carried in decoded word bits [1:0]
    localparam logic [1:0] TY_NOP = 2'b00;
    localparam logic [1:0] TY_J   = 2'b01;
    localparam logic [1:0] TY_I   = 2'b10;
    localparam logic [1:0] TY_R   = 2'b11;

    // JAL always writes its return address here
    localparam logic [REG_W-1:0] LINK_REG = 3'd7;

    // Raw instruction field positions
    localparam int I_OP_HI   = 15;
    localparam int I_OP_LO   = 12;
    localparam int I_RD_HI   = 11;
    localparam int I_RD_LO   = 9;
    localparam int I_RS1_HI  = 8;
    localparam int I_RS1_LO  = 6;
    localparam int I_RS2_HI  = 5;
    localparam int I_RS2_LO  = 3;
    localparam int I_IMM6_HI = 5;
    localparam int I_IMM6_LO = 0;
    localparam int I_IMM9_HI = 8;
    localparam int I_IMM9_LO = 0;

    // Decoded word field positions
    localparam int W_RD_HI   = 18;
    localparam int W_RD_LO   = 16;
    localparam int W_RS1_HI  = 15;
    localparam int W_RS1_LO  = 13;
    localparam int W_RS2_HI  = 12;
    localparam int W_RS2_LO  = 10;
    localparam int W_IMM6_HI = 12;
    localparam int W_IMM6_LO = 7;
    localparam int W_IMM9_HI = 15;
    localparam int W_IMM9_LO = 7;
    localparam int W_OP_HI   = 6;
    localparam int W_OP_LO   = 3;
    localparam int W_WE      = 2;
    localparam int W_TY_HI   = 1;
    localparam int W_TY_LO   = 0;

    // Decode stage FSM states
    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_BUBBLE = 2'b01,
        ST_HALT   = 2'b10
    } state_t;

endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: purely combinational translation of a raw 16-bit instruction
// into the 19-bit register-read word, plus load/halt/illegal flags.
// Fields that the decoded type does not use are left at zero.
module instr_decoder
    import isa_pkg::*;
(
    input  logic [15:0] i_instr,
    output logic [18:0] o_word,
    output logic        o_is_load,
    output logic        o_is_halt,
    output logic        o_is_illegal
);

    logic [3:0] w_op;
    logic [2:0] w_rd;
    logic [2:0] w_rs1;
    logic [2:0] w_rs2;
    logic [5:0] w_imm6;
    logic [8:0] w_imm9;

    assign w_op   = i_instr[I_OP_HI:I_OP_LO];
    assign w_rd   = i_instr[I_RD_HI:I_RD_LO];
    assign w_rs1  = i_instr[I_RS1_HI:I_RS1_LO];
    assign w_rs2  = i_instr[I_RS2_HI:I_RS2_LO];
    assign w_imm6 = i_instr[I_IMM6_HI:I_IMM6_LO];
    assign w_imm9 = i_instr[I_IMM9_HI:I_IMM9_LO];

    // Build the decoded word field by field according to the opcode class
    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        o_word       = '0;
        o_is_load    = 1'b0;
        o_is_halt    = 1'b0;
        o_is_illegal = 1'b0;
        case (w_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                o_word[W_RD_HI:W_RD_LO]   = w_rd;
                o_word[W_RS1_HI:W_RS1_LO] = w_rs1;
                o_word[W_RS2_HI:W_RS2_LO] = w_rs2;
                o_word[W_OP_HI:W_OP_LO]   = w_op;
                o_word[W_WE]              = 1'b1;
                o_word[W_TY_HI:W_TY_LO]   = TY_R;
            end
            OP_ADDI, OP_LW, OP_SW, OP_BEQ: begin
                // For SW the rd slot carries the store-data register
                o_word[W_RD_HI:W_RD_LO]     = w_rd;
                o_word[W_RS1_HI:W_RS1_LO]   = w_rs1;
                o_word[W_IMM6_HI:W_IMM6_LO] = w_imm6;
                o_word[W_OP_HI:W_OP_LO]     = w_op;
                o_word[W_WE]                = (w_op == OP_ADDI) || (w_op == OP_LW);
                o_word[W_TY_HI:W_TY_LO]     = TY_I;
                o_is_load                   = (w_op == OP_LW);
            end
            OP_JMP, OP_JAL: begin
                o_word[W_RD_HI:W_RD_LO]     = (w_op == OP_JAL) ? LINK_REG : w_rd;
                o_word[W_IMM9_HI:W_IMM9_LO] = w_imm9;
                o_word[W_OP_HI:W_OP_LO]     = w_op;
                o_word[W_WE]                = (w_op == OP_JAL);
                o_word[W_TY_HI:W_TY_LO]     = TY_J;
            end
            OP_HALT: begin
                o_is_halt = 1'b1;
            end
            OP_NOP: begin
                o_is_halt = 1'b0;
            end
            default: begin
                // 1100..1110 are unassigned: decode as NOP and flag them
                o_is_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: one-cycle registered decode with load-use hazard bubble,
// downstream stall, flush redirect and a sticky HALT state.
module decode_stage
    import isa_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        stall,
    input  logic        in_valid,
    input  logic [15:0] in_instr,
    output logic        in_ready,
    output logic        out_valid,
    output logic [18:0] out_word,
    output logic        halted,
    output logic        illegal
);

    state_t              r_state;
    logic [WORD_W-1:0]   r_word;
    logic                r_valid;
    logic                r_load;
    logic                r_halted;
    logic                r_illegal;

    logic [WORD_W-1:0]   w_dec_word;
    logic                w_dec_load;
    logic                w_dec_halt;
    logic                w_dec_illegal;
    logic                w_hazard;
    logic [REG_W-1:0]    w_load_rd;

    instr_decoder u_decoder (
        .i_instr      (in_instr),
        .o_word       (w_dec_word),
        .o_is_load    (w_dec_load),
        .o_is_halt    (w_dec_halt),
        .o_is_illegal (w_dec_illegal)
    );

    assign w_load_rd = r_word[W_RD_HI:W_RD_LO];

    // Load-use hazard: the word now leaving is LW and the incoming one reads its rd
    always_comb begin
        w_hazard = 1'b0;
        if ((r_state == ST_RUN) && in_valid && r_load) begin
            case (w_dec_word[W_TY_HI:W_TY_LO])
                TY_R: begin
                    w_hazard = (w_dec_word[W_RS1_HI:W_RS1_LO] == w_load_rd) ||
                               (w_dec_word[W_RS2_HI:W_RS2_LO] == w_load_rd);
                end
                TY_I: begin
                    w_hazard = (w_dec_word[W_RS1_HI:W_RS1_LO] == w_load_rd) ||
                               ((w_dec_word[W_OP_HI:W_OP_LO] == OP_SW) &&
                                (w_dec_word[W_RD_HI:W_RD_LO] == w_load_rd));
                end
                default: begin
                    w_hazard = 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = resetn && (r_state == ST_RUN) && !stall && !w_hazard;
    assign out_word  = r_word;
    assign out_valid = r_valid;
    assign halted    = r_halted;
    assign illegal   = r_illegal;

    // Control FSM and output register: flush > stall > bubble exit > hazard > accept
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: the asynchronous reset clears every register so outputs are defined the moment resetn falls.
        if (!resetn) begin
            r_state   <= ST_RUN;
            r_word    <= '0;
            r_valid   <= 1'b0;
            r_load    <= 1'b0;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
        end else if (r_state == ST_HALT) begin
            // Only reset leaves HALT; the NOP loaded on entry stays put
            r_state <= ST_HALT;
        end else if (flush) begin
            // NOTE: non-blocking assignments let every register sample pre-edge values.
            r_word  <= '0;
            r_valid <= 1'b0;
            r_load  <= 1'b0;
            r_state <= ST_RUN;
        end else if (stall) begin
            r_state <= r_state;
        end else if (r_state == ST_BUBBLE) begin
            r_word  <= '0;
            r_valid <= 1'b0;
            r_load  <= 1'b0;
            r_state <= ST_RUN;
        end else if (w_hazard) begin
            r_word  <= '0;
            r_valid <= 1'b0;
            r_load  <= 1'b0;
            r_state <= ST_BUBBLE;
        end else if (in_valid) begin
            r_word  <= w_dec_word;
            r_valid <= (w_dec_word[W_TY_HI:W_TY_LO] != TY_NOP);
            r_load  <= w_dec_load;
            if (w_dec_halt) begin
                r_halted <= 1'b1;
                r_state  <= ST_HALT;
            end
            if (w_dec_illegal) begin
                r_illegal <= 1'b1;
            end
        end else begin
            r_word  <= '0;
            r_valid <= 1'b0;
            r_load  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed literal checks plus randomized traffic compared
// every cycle against an instruction-level reference model.
module tb_decode_stage;

    logic        clk      = 1'b0;
    logic        resetn   = 1'b1;
    logic        flush    = 1'b0;
    logic        stall    = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_instr = 16'h0000;
    logic        in_ready;
    logic        out_valid;
    logic [18:0] out_word;
    logic        halted;
    logic        illegal;

    int n_checks = 0;
    int n_fail   = 0;

    decode_stage dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .stall     (stall),
        .in_valid  (in_valid),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_word  (out_word),
        .halted    (halted),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Decoded word computed arithmetically from the field layout
    function automatic logic [18:0] ref_word(input logic [15:0] ins);
        int op, rd, rs1, rs2, imm6, imm9, w;
        op   = int'(ins[15:12]);
        rd   = int'(ins[11:9]);
        rs1  = int'(ins[8:6]);
        rs2  = int'(ins[5:3]);
        imm6 = int'(ins[5:0]);
        imm9 = int'(ins[8:0]);
        w    = 0;
        if (op >= 1 && op <= 5)
            w = rd * 65536 + rs1 * 8192 + rs2 * 1024 + op * 8 + 4 + 3;
        else if (op == 6 || op == 7)
            w = rd * 65536 + rs1 * 8192 + imm6 * 128 + op * 8 + 4 + 2;
        else if (op == 8 || op == 9)
            w = rd * 65536 + rs1 * 8192 + imm6 * 128 + op * 8 + 2;
        else if (op == 10)
            w = rd * 65536 + imm9 * 128 + op * 8 + 1;
        else if (op == 11)
            w = 7 * 65536 + imm9 * 128 + op * 8 + 4 + 1;
        return w[18:0];
    endfunction

    // Does the instruction read register x as a source?
    function automatic bit reads_reg(input logic [15:0] ins, input int x);
        int op;
        op = int'(ins[15:12]);
        if (op >= 1 && op <= 5) return (int'(ins[8:6]) == x) || (int'(ins[5:3]) == x);
        if (op == 6 || op == 7 || op == 9) return int'(ins[8:6]) == x;
        if (op == 8) return (int'(ins[8:6]) == x) || (int'(ins[11:9]) == x);
        return 1'b0;
    endfunction

    logic [18:0] m_word    = '0;
    bit          m_valid   = 1'b0;
    bit          m_halt    = 1'b0;
    bit          m_bubble  = 1'b0;
    bit          m_halted  = 1'b0;
    bit          m_illegal = 1'b0;
    int          m_ld_rd   = -1;   // destination of the LW currently on the output, else -1

    function automatic bit exp_hazard();
        return !m_halt && !m_bubble && in_valid && (m_ld_rd >= 0) && reads_reg(in_instr, m_ld_rd);
    endfunction

    function automatic bit exp_ready();
        return resetn && !m_halt && !m_bubble && !stall && !exp_hazard();
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_word <= '0; m_valid <= 1'b0; m_halt <= 1'b0; m_bubble <= 1'b0;
            m_halted <= 1'b0; m_illegal <= 1'b0; m_ld_rd <= -1;
        end else if (m_halt) begin
            m_halt <= 1'b1;
        end else if (flush) begin
            m_word <= '0; m_valid <= 1'b0; m_ld_rd <= -1; m_bubble <= 1'b0;
        end else if (stall) begin
            m_halt <= 1'b0;
        end else if (m_bubble) begin
            m_word <= '0; m_valid <= 1'b0; m_ld_rd <= -1; m_bubble <= 1'b0;
        end else if (exp_hazard()) begin
            m_word <= '0; m_valid <= 1'b0; m_ld_rd <= -1; m_bubble <= 1'b1;
        end else if (in_valid) begin
            m_word  <= ref_word(in_instr);
            m_valid <= (in_instr[15:12] >= 4'd1) && (in_instr[15:12] <= 4'd11);
            m_ld_rd <= (in_instr[15:12] == 4'd7) ? int'(in_instr[11:9]) : -1;
            if (in_instr[15:12] == 4'd15) begin
                m_halt   <= 1'b1;
                m_halted <= 1'b1;
            end
            if (in_instr[15:12] inside {[4'd12:4'd14]}) m_illegal <= 1'b1;
        end else begin
            m_word <= '0; m_valid <= 1'b0; m_ld_rd <= -1;
        end
    end

    // Every-cycle comparison, away from the active edge
    always @(negedge clk) begin
        check("cmp_out_word",  out_word,  m_word);
        check("cmp_out_valid", out_valid, m_valid);
        check("cmp_in_ready",  in_ready,  exp_ready());
        check("cmp_halted",    halted,    m_halted);
        check("cmp_illegal",   illegal,   m_illegal);
    end

    // ---------------- stimulus ----------------
    task automatic go();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rand_instr();
        logic [3:0] op;
        logic [2:0] rd, rs1, rs2, lo;
        op = 4'($urandom_range(0, 15));
        if (op == 4'hF && $urandom_range(0, 9) != 0) op = 4'($urandom_range(1, 11));
        rd  = 3'($urandom_range(0, 3));
        rs1 = 3'($urandom_range(0, 3));
        rs2 = 3'($urandom_range(0, 3));
        lo  = 3'($urandom_range(0, 7));
        return {op, rd, rs1, rs2, lo};
    endfunction

    initial begin
        #1 resetn = 1'b0;
        @(negedge clk);
        check("rst_word",  out_word,  19'h0);
        check("rst_ready", in_ready,  1'b0);
        check("rst_valid", out_valid, 1'b0);
        go();
        resetn = 1'b1;

        // Pin the model against hand-computed words
        check("model_add",  ref_word(16'h1650), 19'h3280F);
        check("model_addi", ref_word(16'h6445), 19'h222B6);

        // ADD r3,r1,r2
        go(); in_valid = 1'b1; in_instr = 16'h1650;
        go(); in_valid = 1'b0;
        @(negedge clk);
        check("add_word",  out_word,  19'h3280F);
        check("add_valid", out_valid, 1'b1);

        // ADDI r2,r1,#5
        go(); in_valid = 1'b1; in_instr = 16'h6445;
        go(); in_valid = 1'b0;
        @(negedge clk);
        check("addi_word", out_word, 19'h222B6);

        // LW r2 then ADD r3,r2,r1: hazard cycle, bubble cycle, then ADD
        go(); in_valid = 1'b1; in_instr = 16'h7400;
        go(); in_instr = 16'h1688;
        @(negedge clk);
        check("lw_word",     out_word, 19'h2003E);
        check("hz_ready",    in_ready, 1'b0);
        go();
        @(negedge clk);
        check("bubble_ready", in_ready, 1'b0);
        check("bubble_word",  out_word, 19'h0);
        go();
        @(negedge clk);
        check("post_bubble_ready", in_ready, 1'b1);
        go(); in_valid = 1'b0;
        @(negedge clk);
        check("lu_add_word",  out_word,  19'h3440F);
        check("lu_add_valid", out_valid, 1'b1);

        // Stall held three cycles, then flush together with stall
        go(); in_valid = 1'b1; in_instr = 16'h1650;
        go(); stall = 1'b1; in_instr = 16'h2650;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_word",  out_word, 19'h3280F);
            check("stall_ready", in_ready, 1'b0);
            go();
        end
        flush = 1'b1;
        go(); flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_word",  out_word,  19'h0);
        check("flush_valid", out_valid, 1'b0);

        // HALT, then valid ADDs and flushes are ignored
        go(); in_valid = 1'b1; in_instr = 16'hF000;
        go(); in_instr = 16'h1650;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("halt_halted", halted,    1'b1);
            check("halt_valid",  out_valid, 1'b0);
            check("halt_ready",  in_ready,  1'b0);
            go();
            flush = ~flush;
        end
        flush = 1'b0;
        resetn = 1'b0;
        #1;
        check("halt_rst_halted", halted,   1'b0);
        check("halt_rst_ready",  in_ready, 1'b0);
        go(); resetn = 1'b1; in_valid = 1'b1; in_instr = 16'h1650;
        go(); in_valid = 1'b0;
        @(negedge clk);
        check("after_halt_add", out_word, 19'h3280F);

        // Illegal opcode 1101, then a normal ADD
        go(); in_valid = 1'b1; in_instr = 16'hD123;
        go(); in_instr = 16'h1650;
        @(negedge clk);
        check("ill_flag",  illegal,   1'b1);
        check("ill_valid", out_valid, 1'b0);
        check("ill_word",  out_word,  19'h0);
        go(); in_valid = 1'b0;
        @(negedge clk);
        check("ill_add_word", out_word, 19'h3280F);
        check("ill_sticky",   illegal,  1'b1);

        // Randomized traffic, checked by the per-cycle compare process
        for (int c = 0; c < 4000; c++) begin
            go();
            resetn   = ($urandom_range(0, 99) != 0);
            flush    = ($urandom_range(0, 11) == 0);
            stall    = ($urandom_range(0, 4) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_instr = rand_instr();
        end
        go();
        resetn = 1'b1; flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
